// File: rtl/arbitro_pkg.sv
// Shared definitions for the round-robin comparator arbiter.
// The optional truth counter is enabled with ARBITRO_ESTADISTICA_EN.
package arbitro_pkg;

  typedef enum logic {
    StLibre  = 1'b0,
    StEspera = 1'b1
  } estado_e;

  localparam int unsigned ANCHO_DATO   = 6;
  localparam int unsigned ESPERA_MAX   = 3;
  localparam int unsigned ANCHO_CUENTA = $clog2(ESPERA_MAX + 1);
  localparam int unsigned ANCHO_ESTAD  = 8;

endpackage

// File: rtl/arbitro_comparador_if.sv
// Requester and comparator bundle of arbitro_comparador.
// The slave modport is the arbiter view; master is the requesters/comparator view.
interface arbitro_comparador_if
  import arbitro_pkg::*;
#(
  parameter int unsigned N_SOL = 4,
  parameter int unsigned W_ID  = $clog2(N_SOL)
) ();

  logic [N_SOL-1:0]            sol;
  logic [ANCHO_DATO*N_SOL-1:0] dato;
  logic [N_SOL-1:0]            ack;
  logic                        resultado;
  logic [W_ID-1:0]             concesion;
  logic                        ocupado;
  logic [ANCHO_DATO-1:0]       comp_entrada;
  logic                        comp_salida;

  modport slave (
    input  sol,
    input  dato,
    input  comp_salida,
    output ack,
    output resultado,
    output concesion,
    output ocupado,
    output comp_entrada
  );

  modport master (
    output sol,
    output dato,
    output comp_salida,
    input  ack,
    input  resultado,
    input  concesion,
    input  ocupado,
    input  comp_entrada
  );

endinterface

// File: rtl/arbitro_rr.sv
// Combinational round-robin picker: first eligible requester after ultimo_i, with wrap.
module arbitro_rr #(
  parameter int unsigned N_SOL = 4,
  parameter int unsigned W_ID  = $clog2(N_SOL)
) (
  input  logic [N_SOL-1:0] elegible_i,
  input  logic [W_ID-1:0]  ultimo_i,
  output logic [W_ID-1:0]  ganador_o,
  output logic             valido_o
);

  localparam int unsigned WC = W_ID + 1;

  logic [WC-1:0] cand;

  always_comb begin
    ganador_o = '0;
    valido_o  = 1'b0;
    cand      = '0;
    // Offsets 1..N_SOL visit every requester once, ending on ultimo_i itself.
    for (int unsigned k = 1; k <= N_SOL; k++) begin
      cand = {1'b0, ultimo_i} + WC'(k);
      if (cand >= WC'(N_SOL)) begin
        cand = cand - WC'(N_SOL);
      end
      if (!valido_o && elegible_i[cand[W_ID-1:0]]) begin
        valido_o  = 1'b1;
        ganador_o = cand[W_ID-1:0];
      end
    end
  end

endmodule

// File: rtl/arbitro_comparador.sv
// Shares one combinational comparator among N_SOL requesters, round-robin.
// Define ARBITRO_ESTADISTICA_EN to add the cuenta_verdad_o true-result counter.
module arbitro_comparador
  import arbitro_pkg::*;
#(
  parameter int unsigned N_SOL  = 4,
  parameter int unsigned ESPERA = 1,
  parameter int unsigned W_ID   = $clog2(N_SOL)
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  arbitro_comparador_if.slave io
`ifdef ARBITRO_ESTADISTICA_EN
  ,
  output logic [ANCHO_ESTAD-1:0] cuenta_verdad_o
`endif
);

  estado_e                 estado_q, estado_d;
  logic [ANCHO_CUENTA-1:0] cuenta_q, cuenta_d;
  logic [W_ID-1:0]         ultimo_q, ultimo_d;
  logic [W_ID-1:0]         concesion_q, concesion_d;
  logic [N_SOL-1:0]        ack_q, ack_d;
  logic                    resultado_q, resultado_d;
  logic [ANCHO_DATO-1:0]   entrada_q, entrada_d;

  logic [N_SOL-1:0]      elegible;
  logic [W_ID-1:0]       ganador;
  logic                  hay_elegible;
  logic [ANCHO_DATO-1:0] dato_ganador;
  logic                  fin;

  // A requester whose Ack is high this cycle may still hold Sol; do not serve it twice.
  assign elegible = io.sol & ~ack_q;
  assign fin      = (estado_q == StEspera) && (cuenta_q == '0);

  arbitro_rr #(
    .N_SOL (N_SOL),
    .W_ID  (W_ID)
  ) u_rr (
    .elegible_i (elegible),
    .ultimo_i   (ultimo_q),
    .ganador_o  (ganador),
    .valido_o   (hay_elegible)
  );

  always_comb begin
    dato_ganador = '0;
    for (int unsigned i = 0; i < N_SOL; i++) begin
      if (ganador == W_ID'(i)) begin
        dato_ganador = io.dato[i*ANCHO_DATO +: ANCHO_DATO];
      end
    end
  end

  always_comb begin
    estado_d    = estado_q;
    cuenta_d    = cuenta_q;
    ultimo_d    = ultimo_q;
    concesion_d = concesion_q;
    ack_d       = '0;
    resultado_d = resultado_q;
    entrada_d   = entrada_q;

    unique case (estado_q)
      StLibre: begin
        if (hay_elegible) begin
          entrada_d   = dato_ganador;
          concesion_d = ganador;
          cuenta_d    = ANCHO_CUENTA'(ESPERA);
          estado_d    = StEspera;
        end
      end
      StEspera: begin
        if (cuenta_q != '0) begin
          cuenta_d = cuenta_q - 1'b1;
        end else begin
          resultado_d        = io.comp_salida;
          ack_d[concesion_q] = 1'b1;
          ultimo_d           = concesion_q;
          estado_d           = StLibre;
        end
      end
      default: estado_d = StLibre;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      estado_q    <= StLibre;
      cuenta_q    <= '0;
      ultimo_q    <= W_ID'(N_SOL - 1);
      concesion_q <= '0;
      ack_q       <= '0;
      resultado_q <= 1'b0;
      entrada_q   <= '0;
    end else begin
      estado_q    <= estado_d;
      cuenta_q    <= cuenta_d;
      ultimo_q    <= ultimo_d;
      concesion_q <= concesion_d;
      ack_q       <= ack_d;
      resultado_q <= resultado_d;
      entrada_q   <= entrada_d;
    end
  end

  assign io.ack          = ack_q;
  assign io.resultado    = resultado_q;
  assign io.concesion    = concesion_q;
  assign io.ocupado      = (estado_q == StEspera);
  assign io.comp_entrada = entrada_q;

`ifdef ARBITRO_ESTADISTICA_EN
  logic [ANCHO_ESTAD-1:0] cuenta_verdad_q, cuenta_verdad_d;

  // Counts on the completion edge, so the new value appears together with Ack.
  always_comb begin
    cuenta_verdad_d = cuenta_verdad_q;
    if (fin && io.comp_salida) begin
      cuenta_verdad_d = cuenta_verdad_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cuenta_verdad_q <= '0;
    end else begin
      cuenta_verdad_q <= cuenta_verdad_d;
    end
  end

  assign cuenta_verdad_o = cuenta_verdad_q;
`endif

  a_ack_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(ack_q));
  a_ack_pulso  : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                  (ack_q != '0) |=> (ack_q == '0));

endmodule

// File: tb/tb_arbitro_comparador.sv
// Bench for arbitro_comparador: transaction-timing reference model plus directed scenarios.
module tb_arbitro_comparador;
  import arbitro_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned E1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1_n, rst0_n, rst3_n;
  int   total = 0;
  int   bad   = 0;

  arbitro_comparador_if #(.N_SOL(N), .W_ID(2)) if1 ();
  arbitro_comparador_if #(.N_SOL(N), .W_ID(2)) if0 ();
  arbitro_comparador_if #(.N_SOL(N), .W_ID(2)) if3 ();

  logic [N-1:0]   sol_v, sol0_v, sol3_v;
  logic [6*N-1:0] dato_v, dato0_v, dato3_v;
  assign if1.sol  = sol_v;
  assign if1.dato = dato_v;
  assign if0.sol  = sol0_v;
  assign if0.dato = dato0_v;
  assign if3.sol  = sol3_v;
  assign if3.dato = dato3_v;

`ifdef ARBITRO_ESTADISTICA_EN
  logic [7:0] cv1, cv0, cv3;
`endif

  // Comparator: func 00 eq, 01 lt, 10 gt, 11 ne on a=w[3:2], b=w[1:0].
  function automatic logic cmp(input logic [5:0] w);
    case (w[5:4])
      2'b00:   return w[3:2] == w[1:0];
      2'b01:   return w[3:2] <  w[1:0];
      2'b10:   return w[3:2] >  w[1:0];
      default: return w[3:2] != w[1:0];
    endcase
  endfunction

  assign if1.comp_salida = cmp(if1.comp_entrada);
  assign if0.comp_salida = cmp(if0.comp_entrada);

  // Slow comparator: shows the inverted value until two edges after its input changed.
  logic [5:0] ent3_prev = '0;
  int         edad3     = 0;
  always @(posedge clk) begin
    if (if3.comp_entrada != ent3_prev) begin
      ent3_prev <= if3.comp_entrada;
      edad3     <= 0;
    end else if (edad3 < 15) begin
      edad3 <= edad3 + 1;
    end
  end
  assign if3.comp_salida = (edad3 >= 2 && ent3_prev == if3.comp_entrada) ?
                           cmp(if3.comp_entrada) : ~cmp(if3.comp_entrada);

  arbitro_comparador #(.N_SOL(N), .ESPERA(E1), .W_ID(2)) u_dut1 (
    .clk_i  (clk),
    .rst_ni (rst1_n),
    .io     (if1.slave)
`ifdef ARBITRO_ESTADISTICA_EN
    ,
    .cuenta_verdad_o (cv1)
`endif
  );

  arbitro_comparador #(.N_SOL(N), .ESPERA(0), .W_ID(2)) u_dut0 (
    .clk_i  (clk),
    .rst_ni (rst0_n),
    .io     (if0.slave)
`ifdef ARBITRO_ESTADISTICA_EN
    ,
    .cuenta_verdad_o (cv0)
`endif
  );

  arbitro_comparador #(.N_SOL(N), .ESPERA(3), .W_ID(2)) u_dut3 (
    .clk_i  (clk),
    .rst_ni (rst3_n),
    .io     (if3.slave)
`ifdef ARBITRO_ESTADISTICA_EN
    ,
    .cuenta_verdad_o (cv3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model for u_dut1: a grant at edge g completes with Ack at edge g+E1+1,
  // and the arbiter is free again from the edge after that.
  bit         m_busy;
  int         m_fin, m_last, m_who, m_true, cyc;
  logic [5:0] m_word;
  logic       m_res;
  logic [N-1:0] m_ack;

  task automatic modelo_reset();
    m_busy = 0; m_fin = 0; m_last = N - 1; m_who = 0; m_true = 0; cyc = 0;
    m_word = '0; m_res = 1'b0; m_ack = '0;
  endtask

  task automatic ciclo();
    logic [N-1:0] eleg, nack;
    int c;
    @(posedge clk);
    cyc++;
    eleg = sol_v & ~m_ack;
    nack = '0;
    if (m_busy && cyc == m_fin) begin
      nack[m_who] = 1'b1;
      m_res  = cmp(m_word);
      m_last = m_who;
      m_busy = 0;
      if (m_res) m_true++;
    end else if (!m_busy && eleg != '0) begin
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (eleg[c]) begin
          m_who = c;
          break;
        end
      end
      m_word = dato_v[m_who*6 +: 6];
      m_busy = 1;
      m_fin  = cyc + E1 + 1;
    end
    m_ack = nack;
    #1;
    chk("ack", if1.ack, m_ack);
    chk("resultado", if1.resultado, m_res);
    chk("concesion", if1.concesion, m_who);
    chk("ocupado", if1.ocupado, m_busy);
    chk("comp_entrada", if1.comp_entrada, m_word);
`ifdef ARBITRO_ESTADISTICA_EN
    chk("cuenta_verdad", cv1, m_true % 256);
`endif
  endtask

  // Requesters drop Sol in their Ack cycle; with nuevo set, idle ones may raise a request.
  task automatic conducir(input bit nuevo);
    for (int i = 0; i < N; i++) begin
      if (sol_v[i] && m_ack[i]) begin
        sol_v[i] = 1'b0;
      end else if (nuevo && !sol_v[i] && $urandom_range(0, 3) == 0) begin
        sol_v[i] = 1'b1;
        dato_v[i*6 +: 6] = 6'($urandom);
      end
    end
  endtask

  initial begin
    logic [5:0] w;
    int         n, sel;
    bit         want;
    rst1_n = 1'b0; rst0_n = 1'b0; rst3_n = 1'b0;
    sol_v  = 4'b0100;
    dato_v = '0;
    dato_v[17:12] = 6'h12;
    sol0_v = 4'hF;
    dato0_v = 24'($urandom);
    sol3_v = '0;
    dato3_v = '0;
    modelo_reset();
    #2;
    chk("rst_ack", if1.ack, 0);
    chk("rst_resultado", if1.resultado, 0);
    chk("rst_concesion", if1.concesion, 0);
    chk("rst_ocupado", if1.ocupado, 0);
    chk("rst_comp_entrada", if1.comp_entrada, 0);
    @(negedge clk);
    rst1_n = 1'b1; rst0_n = 1'b1; rst3_n = 1'b1;

    // Single request on 2 (ESPERA=1) alongside four saturated requesters (ESPERA=0).
    for (int e = 1; e <= 10; e++) begin
      ciclo();
      chk("rr_e0_ack", if0.ack, (e % 2 == 0) ? (32'd1 << (((e / 2) - 1) % 4)) : 32'd0);
      if (e == 3) begin
        chk("uno_ack", if1.ack, 4'b0100);
        chk("uno_resultado", if1.resultado, 1);
        chk("uno_comp_entrada", if1.comp_entrada, 6'h12);
        chk("uno_concesion", if1.concesion, 2);
        sol_v[2] = 1'b0;
      end
    end
    rst0_n = 1'b0;

    // Requester 1 drops Sol right after its grant.
    sol_v = 4'b0010;
    dato_v[11:6] = 6'($urandom);
    ciclo();
    sol_v[1] = 1'b0;
    ciclo();
    ciclo();
    chk("caida_ack", if1.ack, 4'b0010);
    sol_v = 4'b0101;
    dato_v[5:0]   = 6'($urandom);
    dato_v[17:12] = 6'($urandom);
    ciclo();
    chk("caida_ultimo", if1.concesion, 2);
    for (int i = 0; i < 8; i++) begin
      conducir(1'b0);
      ciclo();
    end
    sol_v = '0;

    // Reset while waiting: request lost, requester 0 wins after release.
    sol_v = 4'b1001;
    dato_v[5:0]   = 6'($urandom);
    dato_v[23:18] = 6'($urandom);
    ciclo();
    chk("abort_ocupado", if1.ocupado, 1);
    #2;
    rst1_n = 1'b0;
    #1;
    chk("abort_ack", if1.ack, 0);
    chk("abort_resultado", if1.resultado, 0);
    chk("abort_concesion", if1.concesion, 0);
    chk("abort_ocupado0", if1.ocupado, 0);
    chk("abort_comp_entrada", if1.comp_entrada, 0);
    modelo_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("abort_sin_ack", if1.ack, 0);
    @(negedge clk);
    rst1_n = 1'b1;
    ciclo();
    chk("abort_gana0", if1.concesion, 0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      conducir(1'b1);
      ciclo();
    end
    for (int i = 0; i < 12; i++) begin
      conducir(1'b0);
      ciclo();
    end

`ifdef ARBITRO_ESTADISTICA_EN
    for (int c = 0; c < 3000 && m_true < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (sol_v[i] && m_ack[i]) begin
          sol_v[i] = 1'b0;
        end else if (!sol_v[i]) begin
          sol_v[i] = 1'b1;
          dato_v[i*6 +: 6] = 6'b11_0001;
        end
      end
      ciclo();
    end
    chk("estad_300", cv1, 44);
    sol_v = '0;
`endif

    // ESPERA=3 against the slow comparator: only the settled value may be sampled.
    for (int t = 0; t < 6; t++) begin
      want = t[0];
      sel  = $urandom_range(0, N - 1);
      w    = 6'($urandom);
      w[5] = w[4];
      if (cmp(w) != want) w[5:4] = ~w[5:4];
      sol3_v = '0;
      sol3_v[sel] = 1'b1;
      dato3_v[sel*6 +: 6] = w;
      n = 0;
      for (int c = 1; c <= 12 && n == 0; c++) begin
        @(posedge clk);
        #1;
        if (if3.ack != '0) n = c;
      end
      chk("e3_latencia", n, 5);
      chk("e3_ack", if3.ack, 32'd1 << sel);
      chk("e3_resultado", if3.resultado, want);
      sol3_v = '0;
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
